reg_wr_arbiter: RTL

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_wr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reg_wr_arbiter.sv
// Register-file write arbiter: merges WB-stage writes with in-order multi-cycle results.
// Define RWA_STALL_STATS_EN to build the saturating stall_cnt counter; otherwise stall_cnt is 0.
module reg_wr_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wr_valid,
  input  logic [ADDR_W-1:0] pipe_wr_addr,
  input  logic [DATA_W-1:0] pipe_wr_data,
  input  logic              div_req_valid,
  input  logic [ADDR_W-1:0] div_req_addr,
  output logic              div_req_ready,
  input  logic              div_res_valid,
  input  logic [DATA_W-1:0] div_res_data,
  output logic              div_res_ready,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic              en_wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] r_tag_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;

  logic              r_hold_vld;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;

  logic              r_en_wr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  w_count;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head;
  logic [DEPTH-1:0]  w_slot_vld;
  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_hit2;

  // Wrap bit differs with equal index bits -> full.
  assign w_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                   (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_count = r_wptr - r_rptr;
  assign w_head  = r_tag_mem[r_rptr[IDX_W-1:0]];

  assign div_req_ready = !w_full;
  assign div_res_ready = !r_hold_vld && !w_empty;
  assign w_push        = div_req_valid && div_req_ready;
  assign w_pop         = div_res_valid && div_res_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wptr[IDX_W-1:0]] <= div_req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Pop only happens with hold empty, so load and drain never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_vld  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_en_wr     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      if (pipe_wr_valid) begin
        r_en_wr   <= 1'b1;
        r_wr_addr <= pipe_wr_addr;
        r_wr_data <= pipe_wr_data;
      end else if (r_hold_vld) begin
        r_en_wr    <= 1'b1;
        r_wr_addr  <= r_hold_addr;
        r_wr_data  <= r_hold_data;
        r_hold_vld <= 1'b0;
      end else begin
        r_en_wr <= 1'b0;
      end
      if (w_pop) begin
        r_hold_vld  <= 1'b1;
        r_hold_addr <= w_head;
        r_hold_data <= div_res_data;
      end
    end
  end

  assign en_wr   = r_en_wr;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // Slot g is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IDX_W-1:0] w_off;
    assign w_off         = IDX_W'(g) - r_rptr[IDX_W-1:0];
    assign w_slot_vld[g] = ({1'b0, w_off} < w_count);
    assign w_hit1[g]     = w_slot_vld[g] && (r_tag_mem[g] == chk_addr1);
    assign w_hit2[g]     = w_slot_vld[g] && (r_tag_mem[g] == chk_addr2);
  end

  always_comb begin
    busy1 = (chk_addr1 != '0) && ((|w_hit1) || (r_hold_vld && (r_hold_addr == chk_addr1)));
    busy2 = (chk_addr2 != '0) && ((|w_hit2) || (r_hold_vld && (r_hold_addr == chk_addr2)));
  end

`ifdef RWA_STALL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_hold_vld && pipe_wr_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
